iter_multiplier: RTL and testbench
==================================

# iter_multiplier

Multi-cycle shift-add multiplier forming the 64-bit product for MIPS `mult`/`multu`, writing `$HI` (upper word) and `$LO` (lower word). It sits beside the iterative divider in the execute stage and shares its `in_valid` / `stall` / `out_valid` handshake, so the pipeline controller drives both units identically. Each operation has a fixed latency regardless of operand values.

## Interface
- `WIDTH`, default 32: operand width. The product is 2*`WIDTH` bits.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: start request. Sampled only in S_IDLE.
- `signed_op`  in  1: 1 selects `mult` (two's complement), 0 selects `multu`. Sampled with `in_valid`.
- `multiplicand`  in  `WIDTH`: operand A, sampled with `in_valid`.
- `multiplier`  in  `WIDTH`: operand B, sampled with `in_valid`.
- `hi`  out  `WIDTH`: product[2W-1:W], destined for `$HI`.
- `lo`  out  `WIDTH`: product[W-1:0], destined for `$LO`.
- `out_valid`  out  1: one-cycle pulse marking a new `hi`/`lo`.
- `stall`  out  1: holds the pipeline while an operation is in flight.

## Operation
- States:
  - S_IDLE: wait for a request.
  - S_OP: `WIDTH` shift-add iterations.
  - S_SIGN: one conditional negation.
  - S_END: present the result.
- Transitions:
  - S_IDLE goes to S_OP when `in_valid`=1.
  - S_OP goes to S_SIGN when the iteration counter reaches `WIDTH`-1.
  - S_SIGN goes to S_END unconditionally.
  - S_END goes to S_IDLE unconditionally.
  - Unused encodings go to S_IDLE.
- Accept (S_IDLE, `in_valid`=1):
  - Latch magnitudes: |A| and |B| when `signed_op`=1, raw operands otherwise.
  - Record `neg` = `signed_op` & (A[W-1] ^ B[W-1]).
  - Clear the 2W-bit accumulator and the counter.
  - The magnitude of -2^(W-1) is the unsigned value 2^(W-1). No overflow special case exists.
- S_OP, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator upper half, keeping the (W+1)-bit carry.
  - Shift {carry, accumulator} right by 1.
  - Shift the multiplier right by 1.
  - Increment the counter.
- S_SIGN: if `neg`, two's-complement the 2W-bit accumulator. Otherwise pass it through.
- S_END:
  - Load the `hi`/`lo` registers from the accumulator on entry.
  - Drive `out_valid`=1 for this cycle.
- `hi`/`lo` hold their value until the next S_END load. Their value is undefined to consumers except while `out_valid` is high.
- `in_valid` in S_OP, S_SIGN or S_END is ignored. No queuing and no restart.
- Operand inputs need not stay stable after the accept cycle.
- Zero operands still take the full latency. There is no early termination.

## Timing
- Reset values: state S_IDLE, `hi`=0, `lo`=0, `out_valid`=0, `stall`=0. Accumulator, counter and `neg` are 0.
- `rst` asserted mid-operation aborts immediately: outputs return to reset values, no `out_valid`.
- Operation cycles, with the accept edge as cycle 0:
  - S_OP occupies cycles 1..`WIDTH`.
  - S_SIGN is cycle `WIDTH`+1.
  - S_END is cycle `WIDTH`+2, with `out_valid`=1. For `WIDTH`=32 that is cycle 34.
- `stall` is combinational: 1 when (S_IDLE & `in_valid`), S_OP or S_SIGN; 0 in S_END and in S_IDLE without `in_valid`.
- `out_valid` is combinational from state. It is high exactly one cycle per operation, coincident with `stall`=0.
- Back-to-back: a new `in_valid` is accepted on the S_IDLE cycle after S_END. Minimum issue interval is `WIDTH`+3 cycles.

## Structure
- Shared package `muldiv_pkg`, reused by the divider:
  - state encodings S_IDLE/S_OP/S_SIGN/S_END;
  - the default `WIDTH`;
  - the counter width ($clog2(`WIDTH`)).
- One sub-module, `cond_negate` (parameterised width, `en` input, combinational two's complement). It is instantiated for both operand magnitudes (width `WIDTH`) and the product (width 2*`WIDTH`).
- All else is in one module: FSM, counter, datapath registers.

## Test plan
- `multu` 0x0000_0003 × 0x0000_0005 -> at cycle 34: `hi`=0x0000_0000, `lo`=0x0000_000F, `out_valid`=1 for one cycle. `stall`=1 on cycles 0..33.
- `multu` 0xFFFF_FFFF × 0xFFFF_FFFF -> `hi`=0xFFFF_FFFE, `lo`=0x0000_0001.
- `mult` 0xFFFF_FFFF (-1) × 0x0000_0007 -> `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFF9. `mult` 0x8000_0000 × 0x8000_0000 -> `hi`=0x4000_0000, `lo`=0x0000_0000.
- `in_valid` pulsed again at cycles 10 and 34 during a 2×3 `multu` -> exactly one `out_valid` at cycle 34 with `lo`=6. The next op is accepted only at cycle 35.
- `rst` asserted at cycle 15 of an operation -> state S_IDLE, `hi`=`lo`=0, `stall`=0, no `out_valid`. A fresh 4×4 `multu` then returns `lo`=0x10 at latency 34.
- Randomised signed and unsigned operands, 1000 ops -> `hi`/`lo` match a 64-bit reference model. `stall` and `out_valid` follow the cycle rules above.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared by the iterative multiplier and divider: FSM encoding, default width, counter sizing.
// Pure declarations; no timing or flow-control behaviour of its own.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_SIGN = 2'd2,
        S_END  = 2'd3
    } state_t;

    // Iteration counter must index 0..w-1; keep at least one bit for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MULDIV_CNT_W = cnt_width(MULDIV_WIDTH);

endpackage

// File: rtl/cond_negate.sv
// Combinational two's-complement negation when en is high, pass-through otherwise.
// Zero latency; no flow control.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/iter_multiplier.sv
// Shift-add multiplier for mult/multu: one accept cycle, WIDTH iterations, sign fix, result.
// Result pulses out_valid at cycle WIDTH+2; stall holds the pipeline, in_valid ignored while busy.
module iter_multiplier
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             out_valid,
    output logic             stall
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    cond_negate #(.W(WIDTH)) u_neg_a (
        .en   (signed_op & multiplicand[WIDTH-1]),
        .din  (multiplicand),
        .dout (mag_a)
    );

    cond_negate #(.W(WIDTH)) u_neg_b (
        .en   (signed_op & multiplier[WIDTH-1]),
        .din  (multiplier),
        .dout (mag_b)
    );

    cond_negate #(.W(2*WIDTH)) u_neg_p (
        .en   (neg_q),
        .din  (acc_q),
        .dout (prod)
    );

    // Carry out of the upper-half add is kept so the right shift never loses it.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = S_OP;
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_OP: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                // hi/lo take the signed result here so they are valid throughout S_END.
                acc_d   = prod;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall     = ((state_q == S_IDLE) && in_valid) || (state_q == S_OP) || (state_q == S_SIGN);
    assign out_valid = (state_q == S_END);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Randomised and directed scoreboard bench for iter_multiplier against a 64-bit arithmetic model.
module tb_iter_multiplier;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          signed_op = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic [W-1:0]  hi, lo;
    logic          out_valid, stall;

    iter_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .signed_op    (signed_op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .out_valid    (out_valid),
        .stall        (stall)
    );

    typedef struct {
        int          e;
        logic [63:0] prod;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (period %0d)", nm, act, exp, cyc + 1);
        end
    endtask

    // Monitor: labels each clock period by the edge that ends it; an op accepted
    // at edge e stalls through period e+W+1 and presents its result in period e+W+2.
    int   p;
    logic es, eo;
    always @(negedge clk) begin
        p  = cyc + 1;
        es = in_valid;
        eo = 1'b0;
        if (rst) begin
            es = 1'b0;
            chk("reset_hi", {32'b0, hi}, 64'd0);
            chk("reset_lo", {32'b0, lo}, 64'd0);
        end else if (q.size() > 0) begin
            if (p > q[0].e && p <= q[0].e + W + 1) begin
                es = 1'b1;
            end else if (p == q[0].e + W + 2) begin
                es = 1'b0;
                eo = 1'b1;
            end
        end
        chk("stall", {63'b0, stall}, {63'b0, es});
        chk("out_valid", {63'b0, out_valid}, {63'b0, eo});
        if (eo) begin
            chk("hi", {32'b0, hi}, {32'b0, q[0].prod[63:32]});
            chk("lo", {32'b0, lo}, {32'b0, q[0].prod[31:0]});
            void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (q.size() != 0) begin
            step();
            guard++;
            if (guard > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_idle: result pending %0d periods, limit 100", guard);
                q.delete();
            end
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp);
        exp_t x;
        wait_idle();
        in_valid     = 1'b1;
        signed_op    = s;
        multiplicand = a;
        multiplier   = b;
        x.e          = cyc + 1;
        x.prod       = exp;
        q.push_back(x);
        step();
        in_valid     = 1'b0;
        signed_op    = $urandom_range(0, 1);
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic pulse_ignored();
        in_valid     = 1'b1;
        signed_op    = $urandom_range(0, 1);
        multiplicand = $urandom;
        multiplier   = $urandom;
        step();
        in_valid     = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic         s;
        logic [W-1:0] a, b;

        repeat (3) step();
        rst = 1'b0;
        step();

        issue(1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(1'b0, 32'h0000_0000, 32'h0001_2345, 64'h0);
        issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // Requests during S_OP and S_END are dropped; the next op goes in at cycle 35.
        issue(1'b0, 32'd2, 32'd3, 64'd6);
        repeat (9) step();
        pulse_ignored();
        repeat (23) step();
        pulse_ignored();
        issue(1'b0, 32'd5, 32'd6, 64'd30);

        // Reset in the middle of an operation aborts it without a result.
        issue(1'b0, 32'd7, 32'd9, 64'd63);
        repeat (14) step();
        rst = 1'b1;
        q.delete();
        repeat (2) step();
        rst = 1'b0;
        issue(1'b0, 32'd4, 32'd4, 64'h10);

        for (int i = 0; i < 1000; i++) begin
            s = $urandom_range(0, 1);
            a = pick_operand();
            b = pick_operand();
            wait_idle();
            repeat ($urandom_range(0, 2)) step();
            issue(s, a, b, ref_prod(s, a, b));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 33)) step();
                pulse_ignored();
            end
        end

        wait_idle();
        repeat (3) step();
        chk("drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
